// File: rtl/ring_seq_monitor.sv
// ring_seq_monitor
// Registered checker and phase decoder for a ring (one-hot) or Johnson
// counter. Samples the counter vector on every enabled cycle and locks onto
// the sequence. While locked it reports the phase index, pulses rev_tick on
// every wrap to phase 0 and counts revolutions. A step that breaks the legal
// successor rule raises a sticky error, bumps a saturating error count and
// drops lock.
//
// Parameters:
//   WIDTH  counter vector width (>= 2)
//   MODE   0 = one-hot ring sequence, 1 = Johnson sequence
//   REV_W  revolution counter width
//   ERR_W  error counter width
//   PW     (local) phase index width, $clog2(2*WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   en         sample enable; low holds all state and forces rev_tick to 0
//   in_vec     counter state from the upstream counter
//   clr_err    synchronous clear of err / err_cnt (an error event wins)
//   phase      decoded phase of the last accepted sample
//   phase_vld  phase is meaningful (same as locked)
//   locked     monitor is tracking the sequence
//   rev_tick   one-cycle pulse on wrap from the last phase to phase 0
//   rev_cnt    revolutions seen while locked, wraps
//   err        sticky sequence-error flag
//   err_cnt    saturating error count
//
// Build option:
//   RING_MON_STALL_EN  when defined, a repeated sample while locked is
//                      treated as a stall (no state change, no error);
//                      otherwise it is an error like any other mismatch.

module ring_seq_monitor #(
   parameter  int WIDTH = 4,
   parameter  int MODE  = 0,
   parameter  int REV_W = 8,
   parameter  int ERR_W = 4,
   localparam int PW    = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             clr_err,
   output logic [PW-1:0]    phase,
   output logic             phase_vld,
   output logic             locked,
   output logic             rev_tick,
   output logic [REV_W-1:0] rev_cnt,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int N = (MODE == 0) ? WIDTH : 2 * WIDTH;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] prev;

   logic [WIDTH-1:0] succ;
   logic             legal;
   logic [PW-1:0]    dec_phase;
   logic             step_ok;
   logic             stall;
   logic             err_ev;
   int unsigned      ones;
   int unsigned      trans;
   int unsigned      idx;

   // Pattern classification and phase decode of the incoming sample.
   always_comb begin
      ones      = 0;
      trans     = 0;
      idx       = 0;
      legal     = 1'b0;
      dec_phase = '0;

      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (in_vec[i]) begin
            ones = ones + 1;
            idx  = i;
         end
      end
      for (int unsigned i = 0; i < WIDTH - 1; i++) begin
         if (in_vec[i] != in_vec[i+1]) trans = trans + 1;
      end

      if (MODE == 0) begin
         legal = (ones == 1);
         // Phase k has bit (WIDTH-k) mod WIDTH set, i.e. the set bit walks down.
         dec_phase = (idx == 0) ? '0 : PW'(WIDTH - idx);
      end else begin
         legal = (trans <= 1);
         // Filling half (MSB set) counts ones; draining half counts zeros past WIDTH.
         if (in_vec[WIDTH-1] || (ones == 0)) dec_phase = PW'(ones);
         else                                dec_phase = PW'(2 * WIDTH - ones);
      end
   end

   // Successor of the last accepted sample and the resulting step verdict.
   always_comb begin
      if (MODE == 0) succ = {prev[0], prev[WIDTH-1:1]};
      else           succ = {~prev[0], prev[WIDTH-1:1]};

      step_ok = (in_vec == succ);
`ifdef RING_MON_STALL_EN
      stall = (in_vec == prev);
`else
      stall = 1'b0;
`endif
      err_ev = en && (state == LOCKED) && !step_ok && !stall;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= UNLOCKED;
         prev     <= '0;
         phase    <= '0;
         rev_tick <= 1'b0;
         rev_cnt  <= '0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else begin
         rev_tick <= 1'b0;

         if (en) begin
            case (state)
               UNLOCKED: begin
                  // Illegal samples are ignored while unlocked.
                  if (legal) begin
                     state <= LOCKED;
                     prev  <= in_vec;
                     phase <= dec_phase;
                  end
               end
               LOCKED: begin
                  if (step_ok) begin
                     prev  <= in_vec;
                     phase <= dec_phase;
                     if (phase == PW'(N - 1)) begin
                        rev_tick <= 1'b1;
                        rev_cnt  <= rev_cnt + REV_W'(1);
                     end
                  end else if (!stall) begin
                     // Offending sample is dropped; phase keeps its last value.
                     state <= UNLOCKED;
                  end
               end
               default: state <= UNLOCKED;
            endcase
         end

         // An error in the same cycle as a clear restarts the count at one.
         if (err_ev) begin
            err <= 1'b1;
            if (clr_err)             err_cnt <= ERR_W'(1);
            else if (err_cnt != '1)  err_cnt <= err_cnt + ERR_W'(1);
         end else if (clr_err) begin
            err     <= 1'b0;
            err_cnt <= '0;
         end
      end
   end

   assign locked    = (state == LOCKED);
   assign phase_vld = (state == LOCKED);

endmodule

// File: doc/ring_seq_monitor.md
# ring_seq_monitor

Registered checker and phase decoder placed directly downstream of the ring / Johnson counter. It samples the counter's state vector every enabled cycle and locks onto the sequence. Once locked, it reports a binary phase index, pulses once per full revolution and counts revolutions. It also flags any step that breaks the counter's legal successor rule.

## Interface
- `WIDTH`, 4: width of the counter vector being monitored (≥2)
- `MODE`, 0: 0 = one-hot ring sequence, 1 = Johnson sequence
- `REV_W`, 8: revolution counter width
- `ERR_W`, 4: error counter width
- `PW` (localparam): $clog2(2*WIDTH), phase index width
- `clk` input 1: single clock, rising edge
- `rstn` input 1: asynchronous active-low reset
- `en` input 1: sample enable; low = hold all state, pulses forced 0
- `in_vec` input WIDTH: counter state from upstream counter
- `clr_err` input 1: synchronous clear of `err` and `err_cnt`
- `phase` output PW: decoded phase index of last accepted sample
- `phase_vld` output 1: `phase` meaningful (equals `locked`)
- `locked` output 1: monitor tracking the sequence
- `rev_tick` output 1: one-cycle pulse on wrap from last phase to phase 0
- `rev_cnt` output REV_W: revolutions seen while locked, wraps modulo 2^REV_W
- `err` output 1: sticky sequence-error flag
- `err_cnt` output ERR_W: error count, saturates at all-ones

## Operation
- Period N: WIDTH for MODE 0, 2*WIDTH for MODE 1.
- Successor of the previous accepted sample `p`:
  - MODE 0: {p[0], p[WIDTH-1:1]}
  - MODE 1: {~p[0], p[WIDTH-1:1]}
- Legal patterns:
  - MODE 0: exactly one bit set.
  - MODE 1: at most one adjacent-bit boundary differs.
- Phase decode:
  - MODE 0: phase 0 = 0..01; phase k has bit (WIDTH−k) mod WIDTH set.
  - MODE 1: phase 0 = all-zero. If MSB = 1 or vector = 0, phase = popcount. Otherwise phase = WIDTH + number of zeros.
  - MODE 1 examples, WIDTH=4: 1100→2, 0111→5, 0001→7.
- FSM, two states, reset to UNLOCKED:
  - UNLOCKED, legal sample: store sample, go LOCKED, set phase. No `rev_tick`, even if the sample is phase 0.
  - UNLOCKED, illegal sample: stay. No error is raised while unlocked.
  - LOCKED, sample == successor: store, update phase. If the previous phase was N−1, pulse `rev_tick` and increment `rev_cnt`.
  - LOCKED, sample == previous: stall handling; see Configuration.
  - LOCKED, any other sample: error event. `err` ← 1, `err_cnt` +1 (saturating), go UNLOCKED, `locked` ← 0, `phase` holds its last value. The offending sample is not used to relock; relock happens on the next legal sample.
- Error vs clear, same cycle:
  - `clr_err` with no error event: `err` ← 0, `err_cnt` ← 0.
  - `clr_err` with an error event: error wins, `err` = 1, `err_cnt` = 1.
- `en` = 0: FSM, stored sample, counters and flags hold; `rev_tick` = 0. `clr_err` is still honoured.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `in_vec` sampled at a rising edge with `en` = 1 is reflected on the outputs immediately after that same edge.
- The upstream counter changes after edge k and is therefore observed at edge k+1.
- `rev_tick` is high for exactly one cycle per wrap.
- Reset values: `phase` 0, `phase_vld` 0, `locked` 0, `rev_tick` 0, `rev_cnt` 0, `err` 0, `err_cnt` 0, stored sample 0, FSM UNLOCKED.
- `rstn` asserted mid-operation clears everything immediately, independent of `clk`.
- After `rstn` deassertion, the first legal enabled sample locks one edge later.

## Configuration
- `RING_MON_STALL_EN` defined: in LOCKED, a sample equal to the previous one is a stall. No state change, no error, no `rev_tick`. This tolerates the upstream counter being held in reset or gated.
- Not defined: a repeated sample in LOCKED is an error event like any other mismatch.

## Test plan
- MODE 0, WIDTH 4, stall compiled in; upstream held in reset for 2 cycles (0001) then released; feed 0001,1000,0100,0010,0001 → locks after first edge with phase 0. Phases then read 0,1,2,3,0; `rev_tick` pulses once; `rev_cnt` = 1; `err` stays 0.
- MODE 1, WIDTH 4; feed 0000→1000→…→0001→0000 → phases 0..7 then 0; one `rev_tick`; 1100 decodes to 2 and 0111 to 5.
- MODE 0 locked at phase 1 (1000); inject 0010 → `err` = 1, `err_cnt` = 1, `locked` = 0 next edge; next legal 0100 relocks at phase 2.
- Stall compiled out; hold 0001 for 3 samples → lock, error, unlock, relock alternating; `err_cnt` = 1 after 3 samples, saturates at 15 with ERR_W = 4 over a long hold.
- Error event and `clr_err` in the same cycle, with `err_cnt` previously 3 → `err_cnt` = 1, `err` = 1; `clr_err` alone next cycle → both 0.
- `en` low for 5 cycles mid-revolution while `in_vec` changes → outputs frozen, no error; `rstn` pulse mid-run → all outputs 0 asynchronously.
